// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_pkg
// Brief    : Shared widths, opcodes, FSM states and helpers for alu_arbiter.
// Revision : 1.0
// ============================================================================
package alu_arbiter_pkg;

    localparam int ARB_WORD     = 8;
    localparam int ARB_OP_WIDTH = 3;
    localparam int ARB_NREQ     = 2;

    localparam logic [ARB_OP_WIDTH-1:0] OP_SUM = 3'd0;
    localparam logic [ARB_OP_WIDTH-1:0] OP_SUB = 3'd1;
    localparam logic [ARB_OP_WIDTH-1:0] OP_AND = 3'd2;
    localparam logic [ARB_OP_WIDTH-1:0] OP_OR  = 3'd3;
    localparam logic [ARB_OP_WIDTH-1:0] OP_XOR = 3'd4;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_EXEC = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    function automatic logic [ARB_NREQ-1:0] grant_onehot(input logic i_idx);
        return i_idx ? 2'b10 : 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_if
// Brief    : Request/response bundle between two requesters and alu_arbiter.
// Revision : 1.0
// ============================================================================
interface alu_arbiter_if
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH    = ARB_WORD,
    parameter int OP_WIDTH = ARB_OP_WIDTH,
    parameter int NREQ     = ARB_NREQ
) ();

    logic [NREQ-1:0]          i_req_valid;
    logic [NREQ-1:0]          o_req_ready;
    logic [NREQ*WIDTH-1:0]    i_req_a;
    logic [NREQ*WIDTH-1:0]    i_req_b;
    logic [NREQ*OP_WIDTH-1:0] i_req_op;
    logic [NREQ-1:0]          o_rsp_valid;
    logic [NREQ-1:0]          i_rsp_ready;
    logic [WIDTH-1:0]         o_rsp_result;
    logic                     o_rsp_zero;
    logic                     o_rsp_cf;
    logic                     o_busy;

    modport slave (
        input  i_req_valid, i_req_a, i_req_b, i_req_op, i_rsp_ready,
        output o_req_ready, o_rsp_valid, o_rsp_result, o_rsp_zero, o_rsp_cf, o_busy
    );

    modport master (
        output i_req_valid, i_req_a, i_req_b, i_req_op, i_rsp_ready,
        input  o_req_ready, o_rsp_valid, o_rsp_result, o_rsp_zero, o_rsp_cf, o_busy
    );

endinterface
`default_nettype wire

// File: rtl/alu_arbiter_alu.sv
`default_nettype none
// ============================================================================
// Module   : alu
// Brief    : Combinational ALU producing result, zero and carry/borrow flags.
// Revision : 1.0
// ============================================================================
module alu
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH    = ARB_WORD,
    parameter int OP_WIDTH = ARB_OP_WIDTH
) (
    input  logic [WIDTH-1:0]    i_a,
    input  logic [WIDTH-1:0]    i_b,
    input  logic [OP_WIDTH-1:0] i_op,
    output logic [WIDTH-1:0]    o_result,
    output logic                o_zero,
    output logic                o_cf
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;

    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    // Bit WIDTH of the extended difference is the borrow.
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    always_comb begin
        o_result = i_a;
        o_cf     = 1'b0;
        case (i_op)
            OP_SUM:  {o_cf, o_result} = w_sum;
            OP_SUB:  {o_cf, o_result} = w_diff;
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            default: o_result = i_a;
        endcase
    end

    assign o_zero = (o_result == '0);

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Shares one registered ALU between two valid/ready requesters.
//            Define ALU_ARB_RR_EN for round-robin; default is fixed priority.
// Revision : 1.0
// ============================================================================
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH    = ARB_WORD,
    parameter int OP_WIDTH = ARB_OP_WIDTH,
    parameter int NREQ     = ARB_NREQ
) (
    input  logic          i_clk,
    input  logic          i_rst,
    alu_arbiter_if.slave  bus
);

    arb_state_t          r_state;
    arb_state_t          w_next;
    logic                r_grant;
    logic                r_last_grant;
    logic                w_winner;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [OP_WIDTH-1:0] r_op;
    logic [WIDTH-1:0]    r_result;
    logic                r_zero;
    logic                r_cf;
    logic [WIDTH-1:0]    w_alu_result;
    logic                w_alu_zero;
    logic                w_alu_cf;
    logic [NREQ-1:0]     w_req_ready;
    logic [NREQ-1:0]     w_rsp_valid;
    logic                w_req_fire;
    logic                w_rsp_fire;
    logic                w_busy;

    // With no request pending the winner idles on last_grant; ready stays low anyway.
    always_comb begin
`ifdef ALU_ARB_RR_EN
        if (&bus.i_req_valid)
            w_winner = ~r_last_grant;
        else
            w_winner = ~bus.i_req_valid[0] & (bus.i_req_valid[1] | r_last_grant);
`else
        w_winner = ~bus.i_req_valid[0] & (bus.i_req_valid[1] | r_last_grant);
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_state <= ARB_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_req_ready = '0;
        w_rsp_valid = '0;
        w_req_fire  = 1'b0;
        w_rsp_fire  = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            ARB_IDLE: begin
                w_busy      = 1'b0;
                w_req_ready = bus.i_req_valid & grant_onehot(w_winner);
                w_req_fire  = |w_req_ready;
                if (w_req_fire)
                    w_next = ARB_EXEC;
            end
            ARB_EXEC: w_next = ARB_RESP;
            ARB_RESP: begin
                w_rsp_valid = grant_onehot(r_grant);
                w_rsp_fire  = |(bus.i_rsp_ready & w_rsp_valid);
                if (w_rsp_fire)
                    w_next = ARB_IDLE;
            end
            default: w_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= '0;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_result     <= '0;
            r_zero       <= 1'b0;
            r_cf         <= 1'b0;
        end else begin
            if (w_req_fire) begin
                r_a     <= w_winner ? bus.i_req_a[WIDTH +: WIDTH]       : bus.i_req_a[0 +: WIDTH];
                r_b     <= w_winner ? bus.i_req_b[WIDTH +: WIDTH]       : bus.i_req_b[0 +: WIDTH];
                r_op    <= w_winner ? bus.i_req_op[OP_WIDTH +: OP_WIDTH] : bus.i_req_op[0 +: OP_WIDTH];
                r_grant <= w_winner;
            end
            if (r_state == ARB_EXEC) begin
                r_result <= w_alu_result;
                r_zero   <= w_alu_zero;
                r_cf     <= w_alu_cf;
            end
            if (w_rsp_fire)
                r_last_grant <= r_grant;
        end
    end

    alu #(
        .WIDTH    (WIDTH),
        .OP_WIDTH (OP_WIDTH)
    ) u_alu (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_op     (r_op),
        .o_result (w_alu_result),
        .o_zero   (w_alu_zero),
        .o_cf     (w_alu_cf)
    );

    assign bus.o_req_ready  = w_req_ready;
    assign bus.o_rsp_valid  = w_rsp_valid;
    assign bus.o_rsp_result = r_result;
    assign bus.o_rsp_zero   = r_zero;
    assign bus.o_rsp_cf     = r_cf;
    assign bus.o_busy       = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Directed scoreboard bench for alu_arbiter.
// Revision : 1.0
// ============================================================================
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    typedef struct packed {
        logic       g;
        logic [7:0] res;
        logic       z;
        logic       c;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_arbiter_if bus ();

    alu_arbiter dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int r, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        bus.i_req_a[r*8 +: 8]  = a;
        bus.i_req_b[r*8 +: 8]  = b;
        bus.i_req_op[r*3 +: 3] = op;
    endtask

    // Waits (bounded) for a request handshake, checks the winner, pushes the expected response.
    task automatic accept(input logic eg, input logic [7:0] res, input logic z, input logic c);
        bit done = 0;
        for (int k = 0; k < 8 && !done; k++) begin
            #1;
            if (bus.o_req_ready != 2'b00) begin
                chk("grant_winner", bus.o_req_ready, eg ? 2'b10 : 2'b01);
                sb.push_back('{eg, res, z, c});
                done = 1;
            end
            step();
        end
        if (!done)
            chk("accept_timeout", bus.o_req_ready, eg ? 2'b10 : 2'b01);
    endtask

    // Called in the EXEC cycle; holds the response for 'hold' cycles before consuming it.
    task automatic collect(input int hold);
        exp_t       e;
        logic [1:0] oh;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'(sb.size()), 1);
            return;
        end
        e  = sb.pop_front();
        oh = e.g ? 2'b10 : 2'b01;
        chk("exec_rsp_valid", bus.o_rsp_valid, 2'b00);
        chk("exec_busy", bus.o_busy, 1'b1);
        chk("exec_req_ready", bus.o_req_ready, 2'b00);
        if (hold > 0)
            bus.i_rsp_ready = 2'b00;
        step();
        for (int k = 0; k <= hold; k++) begin
            chk("rsp_valid", bus.o_rsp_valid, oh);
            chk("rsp_result", bus.o_rsp_result, e.res);
            chk("rsp_zero", bus.o_rsp_zero, e.z);
            chk("rsp_cf", bus.o_rsp_cf, e.c);
            chk("rsp_busy", bus.o_busy, 1'b1);
            chk("rsp_req_ready", bus.o_req_ready, 2'b00);
            if (k == hold)
                bus.i_rsp_ready = 2'b11;
            else
                bus.i_rsp_ready = (k == 2) ? ~oh : 2'b00;
            step();
        end
        chk("idle_busy", bus.o_busy, 1'b0);
        chk("idle_rsp_valid", bus.o_rsp_valid, 2'b00);
    endtask

    initial begin
        logic eg;
        rst             = 1'b1;
        bus.i_req_valid = 2'b00;
        bus.i_req_a     = '0;
        bus.i_req_b     = '0;
        bus.i_req_op    = '0;
        bus.i_rsp_ready = 2'b11;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("reset_rsp_valid", bus.o_rsp_valid, 2'b00);
        chk("reset_result", bus.o_rsp_result, 8'h00);
        chk("reset_zero", bus.o_rsp_zero, 1'b0);
        chk("reset_cf", bus.o_rsp_cf, 1'b0);
        chk("reset_busy", bus.o_busy, 1'b0);
        chk("reset_req_ready", bus.o_req_ready, 2'b00);

        // Single request: 3 + 4
        set_req(0, 8'd3, 8'd4, OP_SUM);
        bus.i_req_valid = 2'b01;
        accept(1'b0, 8'd7, 1'b0, 1'b0);
        bus.i_req_valid = 2'b00;
        collect(0);

        // Contention from reset: req0 wins first
        set_req(0, 8'd5, 8'd3, OP_SUB);
        set_req(1, 8'd255, 8'd1, OP_SUM);
        bus.i_req_valid = 2'b11;
        rst = 1'b1;
        step();
        rst = 1'b0;
        accept(1'b0, 8'd2, 1'b0, 1'b0);
        bus.i_req_valid = 2'b10;
        collect(0);
        accept(1'b1, 8'd0, 1'b1, 1'b1);
        bus.i_req_valid = 2'b00;
        collect(0);

        // Sustained contention
        bus.i_req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_RR_EN
            eg = i[0];
`else
            eg = 1'b0;
`endif
            accept(eg, eg ? 8'd0 : 8'd2, eg, eg);
            collect(0);
        end
        bus.i_req_valid = 2'b00;

        // Zero flag via XOR
        set_req(1, 8'hF0, 8'hF0, OP_XOR);
        bus.i_req_valid = 2'b10;
        accept(1'b1, 8'h00, 1'b1, 1'b0);
        bus.i_req_valid = 2'b00;
        collect(0);

        // Backpressure on req1 with a pending req0 and a stray rsp_ready[0]
        set_req(1, 8'd3, 8'd5, OP_SUB);
        bus.i_req_valid = 2'b10;
        accept(1'b1, 8'd254, 1'b0, 1'b1);
        set_req(0, 8'd7, 8'd3, OP_AND);
        bus.i_req_valid = 2'b01;
        collect(5);

        // Reset while in EXEC aborts the pending req0 operation
        accept(1'b0, 8'd3, 1'b0, 1'b0);
        bus.i_req_valid = 2'b00;
        void'(sb.pop_back());
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_rsp_valid", bus.o_rsp_valid, 2'b00);
        chk("abort_result", bus.o_rsp_result, 8'h00);
        chk("abort_busy", bus.o_busy, 1'b0);
        set_req(1, 8'h10, 8'h01, OP_OR);
        bus.i_req_valid = 2'b10;
        #1;
        chk("post_reset_ready", bus.o_req_ready, 2'b10);
        accept(1'b1, 8'h11, 1'b0, 1'b0);
        bus.i_req_valid = 2'b00;
        collect(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one `alu` instance between two requesters (e.g. fetch/address unit and execute unit).
- Per-requester valid/ready request and response handshakes.
- Operands and result are registered, so the combinational ALU stays off both requesters' timing paths.
- Three-state FSM sequences grant, execute and response.

Parameters:
WIDTH, `WORD, operand/result width
OP_WIDTH, `OP_WIDTH, opcode width
NREQ, 2, number of requesters; fixed at 2, other values unsupported

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst  input  1  synchronous active-high reset
i_req_valid  input  NREQ  request valid, bit i = requester i
o_req_ready  output  NREQ  request accepted this cycle, at most one bit high
i_req_a  input  NREQ*WIDTH  operand A, requester i in slice [i*WIDTH +: WIDTH]
i_req_b  input  NREQ*WIDTH  operand B, same packing
i_req_op  input  NREQ*OP_WIDTH  opcode, same packing
o_rsp_valid  output  NREQ  response valid, one-hot to granted requester
i_rsp_ready  input  NREQ  requester consumes response
o_rsp_result  output  WIDTH  registered ALU result, shared by both requesters
o_rsp_zero  output  1  registered zero flag
o_rsp_cf  output  1  registered carry/borrow flag
o_busy  output  1  high whenever FSM is not IDLE

Behaviour:
- Clocking/reset: one clock `i_clk`; reset `i_rst` is synchronous and active-high.
- Reset state:
  - FSM = IDLE; o_rsp_valid = 0; o_rsp_result = 0; o_rsp_zero = 0; o_rsp_cf = 0; o_busy = 0.
  - Operand/op registers cleared; last_grant = 1, so requester 0 wins first.
- Reset asserted in any state aborts the operation in flight; its response is never delivered.
- IDLE:
  - winner = arbitration over i_req_valid.
  - o_req_ready[winner] = 1 only if i_req_valid[winner] = 1. Combinational from i_req_valid and last_grant.
  - On handshake: latch a/b/op of winner, grant = winner, go to EXEC.
  - No valid requests: stay in IDLE.
- EXEC (1 cycle):
  - ALU inputs are the latched registers.
  - At the edge: capture result/zero/cf into output registers, go to RESP.
- RESP:
  - o_rsp_valid[grant] = 1.
  - Outputs hold stable until i_rsp_ready[grant] = 1.
  - On handshake: last_grant = grant, go to IDLE.
  - i_rsp_ready of the non-granted requester is ignored.
- Timing:
  - Latency: request handshake in cycle N → o_rsp_valid high in cycle N+2.
  - Peak throughput: one operation per 3 cycles.
  - o_req_ready = 0 in EXEC and RESP.
- Requester rules:
  - Must hold valid and payload stable until ready.
  - Dropping valid before ready is legal; that request is simply not taken.
- Arithmetic: the arbiter does no arithmetic. Result and flags are exactly the `alu` outputs for the latched inputs. Undefined opcodes are passed through unchanged.
- Arbitration (both valid): see Optional Feature. Single valid: that requester always wins.

Optional Feature:
- Macro: ALU_ARB_RR_EN.
- Defined (round-robin): when both requesters are valid, winner = requester != last_grant. Under sustained contention, grants alternate 0,1,0,1.
- Undefined (fixed priority): requester 0 always wins when valid. last_grant is still maintained but unused; requester 1 can starve.

Decomposition:
- Shared `specs.vh`: `WORD, `OP_WIDTH, `OP_* opcode macros (existing).
- Add to `specs.vh`: state encodings ARB_IDLE = 2'd0, ARB_EXEC = 2'd1, ARB_RESP = 2'd2, and `ARB_NREQ = 2.
- Sub-module: the existing `alu`, instantiated once. Arbitration logic stays inline; no further sub-module.

Test Plan:
- Single request: req0 a=3, b=4, op=`OP_SUM, rsp_ready held high → o_req_ready[0] same cycle; o_rsp_valid = 2'b01 two cycles later; result = 7, cf = 0, zero = 0; back to IDLE next cycle.
- Contention: req0 5 `OP_SUB 3 and req1 255 `OP_SUM 1, both valid from reset → req0 served first (result 2, cf 0); then req1 (result 0, cf 1, zero 1, o_rsp_valid = 2'b10).
- Fairness: both valid continuously for 4 operations → grant order 0,1,0,1 with ALU_ARB_RR_EN defined; 0,0,0,0 without it.
- Backpressure: i_rsp_ready[1] = 0 for 5 cycles during a req1 response (3 `OP_SUB 5) → result 254, cf 1 held stable all 5 cycles; o_req_ready = 0; o_busy = 1; a stray i_rsp_ready[0] pulse has no effect.
- Reset mid-operation: assert i_rsp for 1 cycle while in EXEC → next cycle o_rsp_valid = 0, result = 0, o_busy = 0; a following req1-only request is accepted immediately.
- Zero flag: req1 8'hF0 `OP_XOR 8'hF0 → result 0, zero 1, cf 0.
